// File: rtl/ft600_tx_arbiter.sv
// ft600_tx_arbiter: round-robin arbiter framing per-channel bursts onto the FT600 TX path
module ft600_tx_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int MAX_BURST = 256,
    parameter int HEADER_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NUM_CH-1:0]    src_valid,
    input  logic [NUM_CH*16-1:0] src_data,
    input  logic [NUM_CH-1:0]    src_last,
    output logic [NUM_CH-1:0]    src_ready,
    output logic                 tx_en,
    output logic [15:0]          tx_data,
    input  logic                 tx_full,
    output logic [NUM_CH-1:0]    grant,
    output logic                 busy,
    output logic [31:0]          word_cnt
);
    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] grant_q, grant_d, cont_q, cont_d;
    logic [3:0]        gidx_q, gidx_d, rr_ptr_q, rr_ptr_d;
    logic [15:0]       beat_cnt_q, beat_cnt_d;
    logic [31:0]       word_cnt_q;
    logic              found;
    logic [3:0]        pick;
    logic [4:0]        cand;
    logic [15:0]       sel_data;
    logic              sel_valid, sel_last, sel_cont, beat, burst_end;

    // First valid channel after the last owner, wrapping around
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = 5'(rr_ptr_q) + 5'(k);
            if (cand >= 5'(NUM_CH)) cand = cand - 5'(NUM_CH);
            for (int c = 0; c < NUM_CH; c++)
                if (!found && cand == 5'(c) && src_valid[c]) begin
                    found = 1'b1;
                    pick  = 4'(c);
                end
        end
    end

    // Data word of the current owner
    always_comb begin
        sel_data = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (grant_q[c]) sel_data = src_data[16*c +: 16];
    end

    assign sel_valid = |(src_valid & grant_q);
    assign sel_last  = |(src_last & grant_q);
    assign sel_cont  = |(cont_q & grant_q);
    assign beat      = state_q == DATA && sel_valid && !tx_full;
    assign burst_end = beat && (sel_last || beat_cnt_q == 16'(MAX_BURST - 1));
    assign tx_en     = (state_q == HDR && !tx_full) || beat;
    assign tx_data   = state_q == HDR ? {8'hA5, sel_cont, 3'b000, gidx_q} : sel_data;
    assign src_ready = (state_q == DATA && !tx_full) ? grant_q : '0;
    assign grant     = grant_q;
    assign busy      = state_q != IDLE;
    assign word_cnt  = word_cnt_q;

    // Grant on idle, header then data beats, release at last word or burst cap
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        rr_ptr_d   = rr_ptr_q;
        cont_d     = cont_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: if (en && found) begin
                state_d    = HEADER_EN != 0 ? HDR : DATA;
                grant_d    = NUM_CH'(1) << pick;
                gidx_d     = pick;
                beat_cnt_d = '0;
            end
            HDR: if (!tx_full) state_d = DATA;
            DATA: if (burst_end) begin
                cont_d   = (cont_q & ~grant_q) | (sel_last ? '0 : grant_q);
                rr_ptr_d = gidx_q;
                grant_d  = '0;
                state_d  = IDLE;
            end else if (beat) beat_cnt_d = beat_cnt_q + 16'd1;
            default: state_d = IDLE;
        endcase
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_ptr_q   <= 4'(NUM_CH - 1);
            cont_q     <= '0;
            beat_cnt_q <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            rr_ptr_q   <= rr_ptr_d;
            cont_q     <= cont_d;
            beat_cnt_q <= beat_cnt_d;
            word_cnt_q <= word_cnt_q + 32'(tx_en);
        end
    end
endmodule

// File: tb/tb_ft600_tx_arbiter.sv
// tb_ft600_tx_arbiter: scoreboard bench for the FT600 TX arbiter
module tb_ft600_tx_arbiter;
    localparam int NCH  = 4;
    localparam int MAXB = 4;

    logic             clk = 1'b0, rst_n = 1'b0, en = 1'b0, tx_full = 1'b0;
    logic [NCH-1:0]   src_valid = '0, src_last = '0;
    logic [NCH*16-1:0] src_data = '0;
    logic [NCH-1:0]   src_ready, grant;
    logic             tx_en, busy;
    logic [15:0]      tx_data;
    logic [31:0]      word_cnt;

    int tests = 0, fails = 0;
    int vprob = 100;
    bit full_rand = 1'b0;

    logic [16:0] src_q[NCH][$];
    logic [16:0] exp_q[NCH][$];
    int          exp_hdr[$];

    typedef struct {logic [15:0] d; logic [NCH-1:0] g; int cyc;} log_t;
    log_t tx_log[$];
    int   cyc = 0;

    bit             m_in_burst = 1'b0;
    int             m_ch = 0, m_beats = 0, m_ptr = NCH - 1, e;
    logic [NCH-1:0] m_cont = '0, prev_valid = '0, prev_grant = '0;
    logic           prev_en = 1'b0;
    logic [31:0]    m_cnt = '0;
    logic [16:0]    w;
    log_t           le;

    ft600_tx_arbiter #(.NUM_CH(NCH), .MAX_BURST(MAXB), .HEADER_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .src_valid(src_valid), .src_data(src_data),
        .src_last(src_last), .src_ready(src_ready), .tx_en(tx_en), .tx_data(tx_data),
        .tx_full(tx_full), .grant(grant), .busy(busy), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_word(input int ch, input logic [15:0] d, input logic last);
        src_q[ch].push_back({last, d});
        exp_q[ch].push_back({last, d});
    endtask

    task automatic push_pkt(input int ch, input int len);
        for (int i = 0; i < len; i++) push_word(ch, 16'($urandom), i == len - 1);
    endtask

    function automatic int pending();
        int n = exp_hdr.size();
        for (int c = 0; c < NCH; c++) n += exp_q[c].size();
        return n;
    endfunction

    task automatic drain(input int lim);
        int n = 0;
        while ((busy || pending() != 0) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(pending()), 0);
        chk("drain_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
    endtask

    // Source driver: holds each word until accepted, optional random backpressure
    initial begin
        logic [NCH-1:0] acc;
        forever begin
            @(negedge clk);
            acc = src_valid & src_ready;
            @(posedge clk);
            #1;
            for (int c = 0; c < NCH; c++) begin
                if (!rst_n) src_q[c].delete();
                else if (acc[c] && src_q[c].size() != 0) void'(src_q[c].pop_front());
                if (src_q[c].size() != 0 && ((src_valid[c] && !acc[c] && rst_n) || $urandom_range(99) < 32'(vprob))) begin
                    src_valid[c] = 1'b1;
                    src_data[16*c +: 16] = src_q[c][0][15:0];
                    src_last[c] = src_q[c][0][16];
                end else begin
                    src_valid[c] = 1'b0;
                    src_last[c] = 1'b0;
                end
            end
            if (full_rand) tx_full = $urandom_range(99) < 25;
        end
    end

    // Monitor: parses the TX stream into bursts and checks against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                m_in_burst = 1'b0;
                m_ptr = NCH - 1;
                m_cont = '0;
                m_cnt = '0;
                prev_valid = '0;
                prev_grant = '0;
                prev_en = 1'b0;
                exp_hdr.delete();
                for (int c = 0; c < NCH; c++) exp_q[c].delete();
            end else begin
                chk("word_cnt", word_cnt, m_cnt);
                chk("full_guard", 32'(tx_full && (tx_en || |src_ready)), 0);
                chk("ready_owner", 32'(src_ready & ~grant), 0);
                if (grant != prev_grant && grant != '0) begin
                    chk("grant_from_idle", 32'(prev_grant), 0);
                    chk("grant_en", 32'(prev_en), 1);
                    e = -1;
                    for (int k = 1; k <= NCH; k++)
                        if (e < 0 && prev_valid[(m_ptr + k) % NCH]) e = (m_ptr + k) % NCH;
                    chk("rr_pick", 32'(grant), e < 0 ? 32'd0 : 32'd1 << e);
                    if (e >= 0) exp_hdr.push_back(e);
                end
                if (tx_en) begin
                    le.d = tx_data;
                    le.g = grant;
                    le.cyc = cyc;
                    tx_log.push_back(le);
                    if (!m_in_burst) begin
                        chk("hdr_pending", 32'(exp_hdr.size()), 1);
                        if (exp_hdr.size() != 0) begin
                            m_ch = exp_hdr.pop_front();
                            chk("header", 32'(tx_data), 32'({8'hA5, m_cont[m_ch], 3'b000, 4'(m_ch)}));
                            m_in_burst = 1'b1;
                            m_beats = 0;
                        end
                    end else begin
                        chk("data_pending", 32'(exp_q[m_ch].size() != 0), 1);
                        if (exp_q[m_ch].size() != 0) begin
                            w = exp_q[m_ch].pop_front();
                            chk("data", 32'(tx_data), 32'(w[15:0]));
                            m_beats++;
                            if (w[16] || m_beats == MAXB) begin
                                m_cont[m_ch] = !w[16];
                                m_ptr = m_ch;
                                m_in_burst = 1'b0;
                            end
                        end
                    end
                    m_cnt++;
                end
                prev_valid = src_valid;
                prev_en = en;
                prev_grant = grant;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time %0t reached, required completion earlier", $time);
        $fatal(1);
    end

    initial begin
        logic [15:0] se[4];
        int n;
        se[0] = 16'hA502; se[1] = 16'h1111; se[2] = 16'h2222; se[3] = 16'h3333;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_en", 32'(tx_en), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_src_ready", 32'(src_ready), 0);
        chk("rst_word_cnt", word_cnt, 0);
        rst_n = 1'b1;
        en = 1'b1;
        @(posedge clk);
        #1;

        // single channel burst on ch2
        tx_log.delete();
        push_word(2, 16'h1111, 1'b0);
        push_word(2, 16'h2222, 1'b0);
        push_word(2, 16'h3333, 1'b1);
        drain(200);
        chk("single_len", 32'(tx_log.size()), 4);
        for (int i = 0; i < 4 && i < tx_log.size(); i++) begin
            chk("single_word", 32'(tx_log[i].d), 32'(se[i]));
            chk("single_grant", 32'(tx_log[i].g), 32'b0100);
            chk("single_gap", 32'(tx_log[i].cyc - tx_log[0].cyc), 32'(i));
        end
        chk("single_word_cnt", word_cnt, 4);

        // round-robin between ch0 and ch3 (last owner ch2, so ch3 leads)
        tx_log.delete();
        for (int i = 0; i < 3; i++) begin
            push_word(0, 16'($urandom), 1'b1);
            push_word(3, 16'($urandom), 1'b1);
        end
        drain(200);
        chk("rr_len", 32'(tx_log.size()), 12);
        for (int i = 0; i < 6 && 2 * i < tx_log.size(); i++)
            chk("rr_hdr", 32'(tx_log[2*i].d), i % 2 ? 32'hA500 : 32'hA503);

        // burst cap: 6-word packet then 1-word packet on ch1
        tx_log.delete();
        push_pkt(1, 6);
        push_pkt(1, 1);
        drain(200);
        chk("cap_len", 32'(tx_log.size()), 10);
        if (tx_log.size() >= 9) begin
            chk("cap_hdr0", 32'(tx_log[0].d), 32'hA501);
            chk("cap_hdr_cont", 32'(tx_log[5].d), 32'hA581);
            chk("cap_hdr_clear", 32'(tx_log[8].d), 32'hA501);
        end

        // backpressure in HDR and mid-DATA
        tx_log.delete();
        tx_full = 1'b1;
        push_pkt(2, 3);
        repeat (6) @(posedge clk);
        #1;
        chk("bp_hdr_stall", 32'(tx_log.size()), 0);
        tx_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tx_full = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("bp_data_stall", 32'(tx_log.size()), 2);
        tx_full = 1'b0;
        drain(200);
        chk("bp_len", 32'(tx_log.size()), 4);

        // en gating mid-burst
        tx_log.delete();
        push_pkt(0, 3);
        n = 0;
        while (grant != 4'b0001 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("gate_granted", 32'(grant), 32'b0001);
        @(posedge clk);
        #1;
        en = 1'b0;
        push_pkt(1, 1);
        repeat (15) @(posedge clk);
        #1;
        chk("gate_len", 32'(tx_log.size()), 4);
        chk("gate_grant", 32'(grant), 0);
        chk("gate_busy", 32'(busy), 0);
        en = 1'b1;
        drain(200);
        chk("gate_len2", 32'(tx_log.size()), 6);
        if (tx_log.size() >= 5) chk("gate_hdr", 32'(tx_log[4].d), 32'hA501);

        // async reset during data beat 2
        tx_log.delete();
        push_pkt(0, 3);
        n = 0;
        while (tx_log.size() < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("rst_pre_tx_en", 32'(tx_en), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tx_en", 32'(tx_en), 0);
        chk("rst_mid_grant", 32'(grant), 0);
        chk("rst_mid_word_cnt", word_cnt, 0);
        chk("rst_mid_src_ready", 32'(src_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tx_log.delete();
        for (int c = NCH - 1; c >= 0; c--) push_pkt(c, 1);
        drain(200);
        chk("post_rst_len", 32'(tx_log.size()), 8);
        for (int i = 0; i < NCH && 2 * i < tx_log.size(); i++)
            chk("post_rst_hdr", 32'(tx_log[2*i].d), 32'hA500 + 32'(i));

        // randomized traffic with backpressure, valid gaps and en toggling
        full_rand = 1'b1;
        vprob = 70;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(9) == 0) push_pkt($urandom_range(NCH - 1), $urandom_range(6, 1));
            en = $urandom_range(9) != 0;
            @(posedge clk);
            #1;
        end
        en = 1'b1;
        drain(4000);
        full_rand = 1'b0;
        tx_full = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
